// File: rtl/pp_periph_bus_master.sv
// pp_periph_bus_master: turns single-outstanding core load/store requests into
// one-cycle strobes on the 8-bit-address peripheral register bus.
// Optional feature macro: PP_BUS_RMW_EN. When defined, partial-byte stores run a
// read-modify-write. When undefined, they become full-word writes of req_wdata.
// All bus and response outputs are registered; req_ready is a decode of the
// state register.

module pp_periph_bus_master #(
  parameter logic [31:0] PERIPH_BASE = 32'h2000_0000,
  parameter int unsigned BUS_AW      = 8
) (
  input  logic              clk,
  input  logic              rst,
  // Core request / response
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  // Peripheral register bus
  output logic [BUS_AW-1:0] addr,
  output logic              wr,
  output logic              rd,
  output logic [31:0]       data_in,
  input  logic [31:0]       data_out
);

`ifdef PP_BUS_RMW_EN
  localparam bit RmwEn = 1'b1;
`else
  localparam bit RmwEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdCapt,
    StWrIssue,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Request fields captured on acceptance
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rmw_q, rmw_d;

  // Next values of the registered outputs
  logic [BUS_AW-1:0] addr_d;
  logic              wr_d, rd_d;
  logic [31:0]       data_in_d;
  logic              rsp_valid_d;
  logic [31:0]       rsp_rdata_d;
  logic              rsp_err_d;

  logic win_hit;
  logic be_full;
  logic be_none;

  // Byte-granular addressing is not supported by the bus; the low bits are dropped.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  assign win_hit   = (req_addr[31:10] == PERIPH_BASE[31:10]);
  assign be_full   = (req_be == 4'hF);
  assign be_none   = (req_be == 4'h0);
  assign req_ready = (state_q == StIdle);

  // Byte i comes from the store data when its enable is set, else from the read word.
  function automatic logic [31:0] merge_word(input logic [31:0] wdata,
                                             input logic [31:0] rdata,
                                             input logic [3:0]  be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
    end
    return m;
  endfunction

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rmw_d       = rmw_q;
    addr_d      = addr;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    data_in_d   = data_in;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          wdata_d = req_wdata;
          be_d    = req_be;
          rmw_d   = 1'b0;
          if (!win_hit) begin
            // Out-of-window: answer immediately, bus untouched
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else if (!req_we) begin
            state_d = StRdIssue;
            rd_d    = 1'b1;
            addr_d  = req_addr[BUS_AW+1:2];
          end else if (be_none) begin
            // Empty store: acknowledge without a write strobe
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'h0;
          end else if (be_full || !RmwEn) begin
            state_d   = StWrIssue;
            wr_d      = 1'b1;
            addr_d    = req_addr[BUS_AW+1:2];
            data_in_d = req_wdata;
          end else begin
            state_d = StRdIssue;
            rd_d    = 1'b1;
            addr_d  = req_addr[BUS_AW+1:2];
            rmw_d   = 1'b1;
          end
        end
      end

      StRdIssue: begin
        // Peripheral presents data_out during the next cycle
        state_d = StRdCapt;
      end

      StRdCapt: begin
        if (rmw_q) begin
          state_d   = StWrIssue;
          wr_d      = 1'b1;
          data_in_d = merge_word(wdata_q, data_out, be_q);
        end else begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = data_out;
        end
      end

      StWrIssue: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rmw_q ? data_in : 32'h0;
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, captured request and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      rmw_q     <= 1'b0;
      addr      <= '0;
      wr        <= 1'b0;
      rd        <= 1'b0;
      data_in   <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rmw_q     <= rmw_d;
      addr      <= addr_d;
      wr        <= wr_d;
      rd        <= rd_d;
      data_in   <= data_in_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_pp_periph_bus_master.sv
// Testbench for pp_periph_bus_master: directed requests, a register-file model
// on the peripheral side, a response scoreboard and a bus-protocol monitor.

module tb_pp_periph_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  addr;
  logic        wr;
  logic        rd;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Monitor state
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;
  logic [7:0]  last_rd_addr = 8'h0;
  logic [7:0]  last_wr_addr = 8'h0;
  logic [31:0] last_wr_data = 32'h0;
  logic [32:0] sb [$];  // {err, rdata}

  logic [31:0] mem [256];

  pp_periph_bus_master dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .addr      (addr),
    .wr        (wr),
    .rd        (rd),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Peripheral register file: data_out is valid only in the cycle after rd
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h05] <= 32'h0000_00A5;
      mem[8'h10] <= 32'h1122_3344;
      mem[8'h01] <= 32'h0101_0101;
      mem[8'h03] <= 32'h0303_0303;
      mem[8'hFF] <= 32'hCAFE_F00D;
      data_out   <= 32'h0;
    end else begin
      data_out <= rd ? mem[addr] : 32'hDEAD_BEEF;
      if (wr) mem[addr] <= data_in;
    end
  end

  // Bus protocol monitor
  always @(negedge clk) begin
    if (!rst && (rd || wr)) begin
      chk("rd_wr_exclusive", {31'h0, rd & wr}, 32'h0);
      chk("rd_not_adjacent", {31'h0, rd & prev_rd}, 32'h0);
      chk("wr_not_adjacent", {31'h0, wr & prev_wr}, 32'h0);
    end
    if (!rst && rd) begin
      rd_cnt++;
      last_rd_addr = addr;
    end
    if (!rst && wr) begin
      wr_cnt++;
      last_wr_addr = addr;
      last_wr_data = data_in;
    end
    prev_rd = rd;
    prev_wr = wr;
  end

  // Response scoreboard
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      chk("rsp_expected", {31'h0, sb.size() != 0}, 32'h1);
      if (sb.size() != 0) begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e[32]});
      end
    end
  end

  // One request; called at a negedge with the DUT idle
  task automatic do_req(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_rd, input int exp_wr);
    int c0, rd0, wr0, lat;
    bit seen;
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    c0  = cyc;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    sb.push_back({exp_err, exp_rdata});
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        lat  = cyc - c0;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_rsp_seen"}, {31'h0, seen}, 32'h1);
    chk({tag, "_latency"}, lat, exp_lat);
    @(negedge clk);
    chk({tag, "_rd_pulses"}, rd_cnt - rd0, exp_rd);
    chk({tag, "_wr_pulses"}, wr_cnt - wr0, exp_wr);
  endtask

  initial begin
    int rd0, busy, waitc;
    bit seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_be    = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_addr", {24'h0, addr}, 32'h0);
    chk("rst_wr_rd", {30'h0, wr, rd}, 32'h0);
    chk("rst_data_in", data_in, 32'h0);
    @(negedge clk);

    // Load
    do_req("load", 1'b0, 32'h2000_0014, 32'h0, 4'h0, 32'h0000_00A5, 1'b0, 3, 1, 0);
    chk("load_addr", {24'h0, last_rd_addr}, 32'h05);

    // Full store, then read it back
    do_req("store", 1'b1, 32'h2000_0008, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 2, 0, 1);
    chk("store_addr", {24'h0, last_wr_addr}, 32'h02);
    chk("store_data", last_wr_data, 32'h1234_5678);
    do_req("readback", 1'b0, 32'h2000_000B, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 3, 1, 0);

    // Out-of-window requests; addr holds its last value
    do_req("miss_load", 1'b0, 32'h3000_0000, 32'h0, 4'h0, 32'h0, 1'b1, 1, 0, 0);
    chk("addr_hold", {24'h0, addr}, 32'h02);
    do_req("miss_store", 1'b1, 32'h2000_0400, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1, 0, 0);

    // Top of window
    do_req("top_load", 1'b0, 32'h2000_03FC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 3, 1, 0);
    chk("top_addr", {24'h0, last_rd_addr}, 32'hFF);

    // Empty store
    do_req("be0_store", 1'b1, 32'h2000_0008, 32'hAAAA_AAAA, 4'h0, 32'h0, 1'b0, 1, 0, 0);

    // Partial store
`ifdef PP_BUS_RMW_EN
    do_req("part_store", 1'b1, 32'h2000_0040, 32'h0000_AB00, 4'b0010,
           32'h1122_AB44, 1'b0, 4, 1, 1);
    chk("part_data", last_wr_data, 32'h1122_AB44);
`else
    do_req("part_store", 1'b1, 32'h2000_0040, 32'h0000_AB00, 4'b0010,
           32'h0, 1'b0, 2, 0, 1);
    chk("part_data", last_wr_data, 32'h0000_AB00);
`endif
    chk("part_addr", {24'h0, last_wr_addr}, 32'h10);

    // Three back-to-back loads with req_valid held high
    rd0  = rd_cnt;
    busy = 0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h2000_0000 + 32'((i + 1) * 4);
      waitc = 0;
      while (!req_ready && waitc < 10) begin
        busy++;
        waitc++;
        @(negedge clk);
      end
      chk("b2b_accept", {31'h0, req_ready}, 32'h1);
      if (i == 0) sb.push_back({1'b0, 32'h0101_0101});
      else if (i == 1) sb.push_back({1'b0, 32'h1234_5678});
      else sb.push_back({1'b0, 32'h0303_0303});
      @(negedge clk);
    end
    req_valid = 1'b0;
    waitc = 0;
    while (sb.size() != 0 && waitc < 20) begin
      waitc++;
      @(negedge clk);
    end
    chk("b2b_all_rsp", sb.size(), 0);
    chk("b2b_busy_seen", {31'h0, busy != 0}, 32'h1);
    chk("b2b_rd_pulses", rd_cnt - rd0, 3);
    @(negedge clk);

    // Reset during RD_CAPT aborts the load with no response
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h2000_0014;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_req_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_rsp", {31'h0, seen}, 32'h0);

    // Still functional after the abort
    do_req("post_rst_load", 1'b0, 32'h2000_0014, 32'h0, 4'h0, 32'h0000_00A5, 1'b0, 3, 1, 0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
